base9_counter_display: RTL and testbench
========================================

# base9_counter_display

Two-digit base-9 counter stage that consumes the level output of the team's D latch with reset (the latched `Q` drives `STEP` here). It synchronises `STEP`, detects its rising edges and advances a two-digit counter (00..88, base 9) up or down. It also supports a synchronous parallel load, a terminal-count pulse and registered seven-segment outputs for both digits. It is the stage between the latch and the board display in the base-9 BCD counter example.

## Interface

Parameters:
- `BASE`, default 9. Digit radix; legal range 2..10. Each digit counts 0..BASE-1.
- `SEG_ACTIVE_LOW`, default 0. When 1, all `SEG*` bits are inverted.

Ports:
- `CLK`  in  1  Single clock; all state changes on its rising edge.
- `R`  in  1  Reset, asynchronous, active-low.
- `STEP`  in  1  Count request level from the upstream latch; asynchronous to `CLK`.
- `UP`  in  1  Direction: 1 counts up, 0 counts down. Sampled on the update edge.
- `LOAD`  in  1  Synchronous load request.
- `LD_VAL`  in  8  Load value: [7:4] is the tens digit, [3:0] is the units digit.
- `D1`, `D0`  out  4 each  Tens and units digit registers.
- `TC`  out  1  Terminal-count pulse, one `CLK` cycle wide.
- `SEG1`, `SEG0`  out  7 each  Registered segment patterns for `D1`/`D0`. Bit order is gfedcba (bit0 = a).

## Operation

- **Synchroniser and edge detect**
  - Three-flop chain: s1 <= STEP, s2 <= s1, s3 <= s2.
  - All three flops reset to 1, so a `STEP` that is high at reset release produces no event.
  - Step event: `evt = s2 & ~s3`. Only a 0->1 transition of `STEP` counts.
  - A high level held for any duration counts once.
- **Counter priority, per edge**
  1. `R` low: asynchronous clear.
  2. `LOAD`.
  3. `evt`.
  4. Hold.
- **Load**
  - D1 <= min(LD_VAL[7:4], BASE-1) and D0 <= min(LD_VAL[3:0], BASE-1). Each digit saturates independently.
  - A load never asserts `TC`.
  - An `evt` arriving in the same cycle as `LOAD` is discarded, not deferred.
- **Up count**
  - D0 increments. At BASE-1, D0 wraps to 0 and D1 increments.
  - At value (BASE-1, BASE-1) the counter wraps to 00 and `TC` = 1 on that same edge.
- **Down count**
  - D0 decrements. At 0, D0 wraps to BASE-1 and D1 decrements.
  - At 00 the counter wraps to (BASE-1, BASE-1) and `TC` = 1.
- **`TC`**
  - Registered; high for exactly the one cycle after the wrapping edge, otherwise 0.
- **Segment registers**
  - `SEGn` <= encode(Dn) one edge after `Dn` changes.
  - Encoding (hex, active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Out-of-range codes cannot occur. If they did, the decoder outputs 00.
- **Reset values**
  - s1..s3 = 1. D1 = D0 = 0. TC = 0.
  - SEG1 = SEG0 = 3F, or 40 when `SEG_ACTIVE_LOW` = 1.

## Timing

- `STEP` rising, first sampled high at edge k:
  - `evt` is true between edges k+1 and k+2.
  - `D1`/`D0` and `TC` update at edge k+2.
  - `SEG*` update at edge k+3.
- `LOAD` high at edge k: digits update at edge k, `SEG*` at edge k+1.
- Minimum `STEP` high or low time for guaranteed detection: 2 `CLK` periods. Shorter pulses may be missed; they are never double-counted.
- `R` assertion clears all state immediately, independent of `CLK`, including mid-count and mid-pulse of `TC`. An in-flight edge is lost.
- `R` deassertion: the first counting edge is possible no earlier than 3 edges after release.

## Test plan

- **Reset:** `R`=0 for 3 cycles with `STEP`=1 held through release -> D1:D0=00, TC=0, SEG0=SEG1=3F; no count after release.
- **Single step up:** `UP`=1, `STEP` 0->1 held 20 cycles -> count 00->01 exactly once, 2 edges after first sample; `SEG0`=06 one edge later.
- **Up wrap:** load 0x88, then step up -> D1:D0=00, TC high for exactly 1 cycle. Load 0x08, then step -> 10, TC=0.
- **Down wrap and borrow:** `UP`=0 from 00 -> 88 with TC=1. From 10 -> 08, TC=0.
- **Load saturation and priority:** `LD_VAL`=0x9F with `LOAD`=1 in the same cycle as `evt` -> D1:D0=88, no increment, TC=0.
- **Async reset mid-operation:** `R` low between `STEP` sampling and the update edge at value 47 -> outputs clear immediately to 00/3F; no TC; no count after `R` returns high.

Source files
------------

// File: rtl/base9_counter_display.sv
// Two-digit base-N counter stage fed by a level from the upstream latch.
// STEP is synchronised, its rising edges advance the counter up or down;
// a synchronous load, a one-cycle terminal-count pulse and registered
// seven-segment patterns for both digits complete the stage.
module base9_counter_display #(
  parameter int BASE           = 9,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       STEP,
  input  logic       UP,
  input  logic       LOAD,
  input  logic [7:0] LD_VAL,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       TC,
  output logic [6:0] SEG1,
  output logic [6:0] SEG0
);

  localparam logic [3:0] MAXD    = 4'(BASE - 1);
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Active-high gfedcba pattern; anything outside 0..9 blanks the digit.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic       s1, s2, s3;
  logic       evt;
  logic [3:0] ld1, ld0;
  logic [3:0] nx1, nx0;
  logic       wrap;

  // Three-flop synchroniser; preset to 1 so a level already high at reset
  // release is not mistaken for a fresh request.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= STEP;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign evt = s2 & ~s3;

  // Load digits saturate independently at the top digit value.
  assign ld1 = (LD_VAL[7:4] > MAXD) ? MAXD : LD_VAL[7:4];
  assign ld0 = (LD_VAL[3:0] > MAXD) ? MAXD : LD_VAL[3:0];

  // Next count value for one step in the requested direction.
  always_comb begin
    nx1  = D1;
    nx0  = D0;
    wrap = 1'b0;
    if (UP) begin
      if (D0 == MAXD) begin
        nx0 = 4'd0;
        if (D1 == MAXD) begin
          nx1  = 4'd0;
          wrap = 1'b1;
        end else begin
          nx1 = D1 + 4'd1;
        end
      end else begin
        nx0 = D0 + 4'd1;
      end
    end else begin
      if (D0 == 4'd0) begin
        nx0 = MAXD;
        if (D1 == 4'd0) begin
          nx1  = MAXD;
          wrap = 1'b1;
        end else begin
          nx1 = D1 - 4'd1;
        end
      end else begin
        nx0 = D0 - 4'd1;
      end
    end
  end

  // Digit registers: load beats a step (a coincident step is dropped);
  // TC is high only for the cycle following a wrapping step.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      D1 <= 4'd0;
      D0 <= 4'd0;
      TC <= 1'b0;
    end else if (LOAD) begin
      D1 <= ld1;
      D0 <= ld0;
      TC <= 1'b0;
    end else if (evt) begin
      D1 <= nx1;
      D0 <= nx0;
      TC <= wrap;
    end else begin
      TC <= 1'b0;
    end
  end

  // Segment patterns follow the digits by one edge.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      SEG1 <= 7'h3F ^ SEG_INV;
      SEG0 <= 7'h3F ^ SEG_INV;
    end else begin
      SEG1 <= enc(D1) ^ SEG_INV;
      SEG0 <= enc(D0) ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_base9_counter_display.sv
// Directed bench for base9_counter_display (BASE=9, active-high segments).
module tb_base9_counter_display;

  logic       CLK = 1'b0;
  logic       R = 1'b0;
  logic       STEP = 1'b1;
  logic       UP = 1'b1;
  logic       LOAD = 1'b0;
  logic [7:0] LD_VAL = 8'h00;
  logic [3:0] D1, D0;
  logic       TC;
  logic [6:0] SEG1, SEG0;

  int n_vec = 0;
  int n_err = 0;

  base9_counter_display #(.BASE(9), .SEG_ACTIVE_LOW(0)) dut (
    .CLK(CLK), .R(R), .STEP(STEP), .UP(UP), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .D1(D1), .D0(D0), .TC(TC), .SEG1(SEG1), .SEG0(SEG0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    LOAD = 1'b1;
    LD_VAL = v;
    tick();
    LOAD = 1'b0;
  endtask

  // Raise STEP; returns just after the counting edge (k+2).
  task automatic step_hi();
    STEP = 1'b1;
    repeat (3) tick();
  endtask

  task automatic step_lo();
    STEP = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // Reset with STEP held high through release
    repeat (3) tick();
    chk("rst_cnt", {D1, D0}, 16'h00);
    chk("rst_tc", TC, 0);
    chk("rst_seg1", SEG1, 16'h3F);
    chk("rst_seg0", SEG0, 16'h3F);
    R = 1'b1;
    repeat (6) tick();
    chk("rel_nocount", {D1, D0}, 16'h00);
    chk("rel_tc", TC, 0);

    // Single step up, held 20 cycles
    step_lo();
    STEP = 1'b1;
    tick();                                   // edge k
    chk("up_k", {D1, D0}, 16'h00);
    tick();                                   // edge k+1
    chk("up_k1", {D1, D0}, 16'h00);
    tick();                                   // edge k+2
    chk("up_k2", {D1, D0}, 16'h01);
    chk("up_seg_lag", SEG0, 16'h3F);
    tick();                                   // edge k+3
    chk("up_seg0", SEG0, 16'h06);
    chk("up_tc", TC, 0);
    repeat (17) tick();
    chk("up_once", {D1, D0}, 16'h01);
    step_lo();

    // Up wrap 88 -> 00
    do_load(8'h88);
    chk("ld88", {D1, D0}, 16'h88);
    tick();
    chk("ld88_seg1", SEG1, 16'h7F);
    chk("ld88_tc", TC, 0);
    step_hi();
    chk("upwrap_cnt", {D1, D0}, 16'h00);
    chk("upwrap_tc", TC, 1);
    tick();
    chk("upwrap_tc_end", TC, 0);
    chk("upwrap_seg0", SEG0, 16'h3F);
    step_lo();

    // Units carry 08 -> 10
    do_load(8'h08);
    step_hi();
    chk("carry_cnt", {D1, D0}, 16'h10);
    chk("carry_tc", TC, 0);
    step_lo();

    // Down wrap 00 -> 88, borrow 10 -> 08
    UP = 1'b0;
    do_load(8'h00);
    step_hi();
    chk("dnwrap_cnt", {D1, D0}, 16'h88);
    chk("dnwrap_tc", TC, 1);
    tick();
    chk("dnwrap_tc_end", TC, 0);
    step_lo();
    do_load(8'h10);
    step_hi();
    chk("borrow_cnt", {D1, D0}, 16'h08);
    chk("borrow_tc", TC, 0);
    step_lo();
    step_hi();
    chk("down_plain", {D1, D0}, 16'h07);
    step_lo();

    // Saturating load coincident with a step event
    UP = 1'b1;
    do_load(8'h23);
    STEP = 1'b1;
    tick();                                   // edge k
    tick();                                   // edge k+1, evt now true
    LOAD = 1'b1;
    LD_VAL = 8'h9F;
    tick();                                   // edge k+2
    LOAD = 1'b0;
    chk("sat_cnt", {D1, D0}, 16'h88);
    chk("sat_tc", TC, 0);
    repeat (3) tick();
    chk("sat_nodefer", {D1, D0}, 16'h88);
    chk("sat_seg0", SEG0, 16'h7F);
    step_lo();

    // Async reset between sampling and update edge at 47
    do_load(8'h47);
    tick();
    STEP = 1'b1;
    tick();                                   // edge k
    tick();                                   // edge k+1
    #1 R = 1'b0;
    #1;
    chk("arst_cnt", {D1, D0}, 16'h00);
    chk("arst_tc", TC, 0);
    chk("arst_seg1", SEG1, 16'h3F);
    chk("arst_seg0", SEG0, 16'h3F);
    repeat (2) tick();
    R = 1'b1;
    repeat (6) tick();
    chk("arst_nocount", {D1, D0}, 16'h00);
    chk("arst_tc_after", TC, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
